// File: rtl/alu_console_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_console_seq
// Purpose  : Board console front end. Conditions four push-buttons
//            (synchroniser + debounce + rising-edge pulse), captures signed
//            operands A/B and an opcode from the switches, runs a small ALU
//            and registers the result with status flags for the LED bank.
//            Direct mode uses one button per register; guided mode walks
//            A -> B -> Op -> SHOW on a single button.
// Ports    : clk    - system clock, rising edge
//            rst_n  - synchronous reset, active low
//            valor  - switch value used for every capture
//            btn    - raw buttons [0] A/step [1] B [2] Op [3] execute
//            mode   - 0 direct, 1 guided (asynchronous, synchronised here)
//            leds   - registered result
//            flags  - {err, ovf, carry, zero} of last executed op
//            valid  - result registered since last capture / mode change
//            state  - guided FSM state, 00 in direct mode
// Revision : 1.0 - initial release
// ============================================================================
module alu_console_seq #(
  parameter int SIZE    = 8,
  parameter int OP_W    = 6,
  parameter int DEB_CYC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] valor,
  input  logic [3:0]      btn,
  input  logic            mode,
  output logic [SIZE-1:0] leds,
  output logic [3:0]      flags,
  output logic            valid,
  output logic [1:0]      state
);

  localparam int CW = $clog2(DEB_CYC + 1);

  localparam logic [OP_W-1:0] OP_SRL = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_SRA = OP_W'(6'b000011);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(6'b100100);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_NOR = OP_W'(6'b100111);

  localparam logic [SIZE-1:0] SIZE_V = SIZE'(SIZE);

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    WAIT_OP = 2'b10,
    SHOW    = 2'b11
  } gstate_t;

  // --------------------------------------------------------------------------
  // Button conditioning
  // --------------------------------------------------------------------------
  logic [3:0] btn_s1, btn_s2;
  logic [3:0] stable, stable_d;
  logic [3:0] press;
  logic       mode_s1, mode_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      stable_d <= '0;
      mode_s1  <= 1'b0;
      mode_s2  <= 1'b0;
    end else begin
      btn_s1   <= btn;
      btn_s2   <= btn_s1;
      stable_d <= stable;
      mode_s1  <= mode;
      mode_s2  <= mode_s1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_deb
      logic [CW-1:0] cnt;
      logic          stable_r;

      // The counter only advances while the synchronised level disagrees
      // with the accepted level; any agreeing sample restarts the count, so
      // a new level needs DEB_CYC+1 consecutive disagreeing samples.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt      <= '0;
          stable_r <= 1'b0;
        end else if (btn_s2[gi] == stable_r) begin
          cnt <= '0;
        end else if (cnt == CW'(DEB_CYC)) begin
          stable_r <= btn_s2[gi];
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign stable[gi] = stable_r;
    end
  endgenerate

  assign press = stable & ~stable_d;

  // The synchronised mode is about to change on this edge.
  logic mode_chg;
  assign mode_chg = mode_s1 ^ mode_s2;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [SIZE-1:0] a, b, a_n, b_n, leds_n;
  logic [OP_W-1:0] op, op_n, valor_op;
  logic [3:0]      flags_n;
  logic            valid_n;
  gstate_t         st, st_n;

  assign valor_op = OP_W'(valor);

  // --------------------------------------------------------------------------
  // ALU: in guided WAIT_OP the opcode comes straight from the switches so
  // the result is produced on the same edge that captures it.
  // --------------------------------------------------------------------------
  logic [OP_W-1:0] alu_op;
  logic [SIZE-1:0] res, diff;
  logic [SIZE:0]   sum_ext;
  logic            err, ovf, carry, zero;

  assign alu_op = (mode_s2 && (st == WAIT_OP)) ? valor_op : op;

  always_comb begin
    res     = '0;
    err     = 1'b0;
    ovf     = 1'b0;
    carry   = 1'b0;
    sum_ext = {1'b0, a} + {1'b0, b};
    diff    = a - b;
    case (alu_op)
      OP_ADD: begin
        res   = sum_ext[SIZE-1:0];
        carry = sum_ext[SIZE];
        ovf   = (a[SIZE-1] == b[SIZE-1]) && (sum_ext[SIZE-1] != a[SIZE-1]);
      end
      OP_SUB: begin
        res   = diff;
        carry = (a < b);
        ovf   = (a[SIZE-1] != b[SIZE-1]) && (diff[SIZE-1] != a[SIZE-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_SRL: res = (b >= SIZE_V) ? '0 : (a >> b);
      OP_SRA: res = (b >= SIZE_V) ? {SIZE{a[SIZE-1]}} : SIZE'($signed(a) >>> b);
      default: err = 1'b1;
    endcase
    zero = (res == '0);
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    a_n     = a;
    b_n     = b;
    op_n    = op;
    leds_n  = leds;
    flags_n = flags;
    valid_n = valid;
    st_n    = st;
    if (mode_chg) begin
      st_n    = WAIT_A;
      valid_n = 1'b0;
    end else if (!mode_s2) begin
      // Execute sees the registers before any same-edge capture; a capture
      // then overrides valid.
      if (press[3]) begin
        leds_n  = res;
        flags_n = {err, ovf, carry, zero};
        valid_n = 1'b1;
      end
      if (press[0]) a_n  = valor;
      if (press[1]) b_n  = valor;
      if (press[2]) op_n = valor_op;
      if (|press[2:0]) valid_n = 1'b0;
    end else if (press[0]) begin
      case (st)
        WAIT_A: begin
          a_n     = valor;
          valid_n = 1'b0;
          st_n    = WAIT_B;
        end
        WAIT_B: begin
          b_n  = valor;
          st_n = WAIT_OP;
        end
        WAIT_OP: begin
          op_n    = valor_op;
          leds_n  = res;
          flags_n = {err, ovf, carry, zero};
          valid_n = 1'b1;
          st_n    = SHOW;
        end
        default: st_n = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a     <= '0;
      b     <= '0;
      op    <= '0;
      leds  <= '0;
      flags <= '0;
      valid <= 1'b0;
      st    <= WAIT_A;
    end else begin
      a     <= a_n;
      b     <= b_n;
      op    <= op_n;
      leds  <= leds_n;
      flags <= flags_n;
      valid <= valid_n;
      st    <= st_n;
    end
  end

  assign state = mode_s2 ? st : WAIT_A;

endmodule
`default_nettype wire

// File: doc/alu_console_seq.md
Name: alu_console_seq

Overview:
- Successor to the board-level ALU operand loader: parametrised-width operand/opcode capture, with the ALU datapath inside the block.
- Adds a debounce and edge-detect stage on every push-button.
- Adds a registered result with status flags.
- Adds a second "guided" mode that captures A, B and Op in sequence from a single button.
- Sits between the board switches/buttons and the LED bank.

Parameters:
- SIZE, 8, operand/result width in bits (≥4).
- OP_W, 6, opcode width (encodings below use the low 6 bits; extra upper bits must be 0).
- DEB_CYC, 4, number of consecutive stable cycles required to accept a button level (≥1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- valor  in  SIZE  switch value (signed) used for every capture.
- btn  in  4  raw buttons, asynchronous: [0] load A / guided step, [1] load B, [2] load Op, [3] execute.
- mode  in  1  0 = direct, 1 = guided; synchronised internally with 2 flops.
- leds  out  SIZE  registered signed result.
- flags  out  4  {err, ovf, carry, zero} for the last executed op.
- valid  out  1  result registered since last capture or mode change.
- state  out  2  guided FSM state (00 WAIT_A, 01 WAIT_B, 10 WAIT_OP, 11 SHOW); 00 in direct mode.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - a, b, op, leds, flags = 0; valid = 0; state = WAIT_A.
  - Debouncer stable levels = 0, counters = 0, synchronisers = 0.
  - A button held through reset yields one pulse after release of reset plus the debounce delay.
- Button conditioning, per bit:
  - 2-flop synchroniser, then debounce counter.
  - The counter increments while the synchronised level ≠ stable level and clears when equal.
  - When the count reaches DEB_CYC, stable takes the new level and the counter clears.
  - Press pulse p[i] = stable rising edge, exactly 1 cycle wide.
  - Latency: raw first sampled high at edge N → p[i] high in cycle N+DEB_CYC+2.
  - Glitches shorter than DEB_CYC cycles produce no pulse.
  - Release produces no pulse.
- Direct mode (mode_s = 0):
  - p[0] → a ← valor; p[1] → b ← valor; p[2] → op ← valor[OP_W-1:0].
  - Any capture clears valid.
  - p[3] → leds, flags ← ALU(a, b, op) using register values before any same-cycle capture; valid ← 1 on the next edge.
  - Simultaneous captures all take effect.
  - Execute together with a capture: the result uses old values and valid ends up 0.
- Guided mode (mode_s = 1), driven only by p[0]; p[1..3] are ignored:
  - WAIT_A: a ← valor, go to WAIT_B, valid ← 0.
  - WAIT_B: b ← valor, go to WAIT_OP.
  - WAIT_OP: op ← valor, compute with the new op in the same edge (leds/flags from a, b, valor), valid ← 1, go to SHOW.
  - SHOW: go to WAIT_A; leds are held.
- Mode change, detected on mode_s: state ← WAIT_A, valid ← 0; a, b, op, leds are kept.
- ALU (SIZE-bit, two's complement), by op:
  - 100000 ADD: a+b; carry = unsigned carry out; ovf = signed overflow.
  - 100010 SUB: a−b; carry = borrow (a < b unsigned); ovf = signed overflow.
  - 100100 AND; 100101 OR; 100110 XOR; 100111 NOR.
  - 000010 SRL: a >> b logical; 000011 SRA: a >>> b arithmetic.
    - Shift amount is b taken as unsigned.
    - If b ≥ SIZE: SRL → 0; SRA → all sign bits.
  - Any other op: leds = 0, err = 1.
  - Flags:
    - zero = (result == 0), including on err.
    - carry and ovf are 0 for non-arithmetic ops.
- Outputs change only on clk edges.
- Reset mid-sequence returns to WAIT_A with all registers cleared.

Test Plan:
- Direct ADD: DEB_CYC=4; load a=0x7F, b=0x01, op=0x20, press btn[3] → leds=0x80, flags={0,1,0,0}, valid=1; p[3] is high exactly in cycle N+6 after btn[3] is first sampled high.
- SUB borrow and zero: a=0x05, b=0x05, op=0x22 → leds=0x00, zero=1, carry=0; then b=0x06 → leds=0xFF, carry=1, ovf=0.
- Shifts: a=0x90, b=0x02: SRA → 0xE4, SRL → 0x24; b=0x09: SRA → 0xFF, SRL → 0x00; op=0x3F → leds=0, err=1, zero=1.
- Debounce: 3-cycle btn[1] glitch → no load; 1-cycle bounces during a 20-cycle press → exactly one b capture.
- Guided: mode=1; step with valor=0x03, 0x04, 0x25 → state 00→01→10→11; leds=0x07 (OR), valid=1; the 4th step returns to 00 with leds held; btn[3] presses are ignored.
- Reset/mode edge cases: rst_n=0 in WAIT_OP → all outputs 0 and state 00 next edge; toggling mode in WAIT_B → state 00, valid 0, a retained; execute and load A in the same cycle → result from old a, valid=0.
